// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch stage.
package fetch_pkg;

  localparam int XLEN = 32;
  localparam int ILEN = 32;
  localparam logic [XLEN-1:0] PC_STEP = 32'd4;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [ILEN-1:0] instr;
  } fetch_entry_t;

  function automatic logic [XLEN-1:0] align_pc(
    input logic [XLEN-1:0] pc
  );
    return {pc[XLEN-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous FIFO of fetch entries with flush and occupancy count.
// DEPTH must be a power of two.
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     flush,
  input  logic                     push,
  input  fetch_entry_t             wdata,
  input  logic                     pop,
  output fetch_entry_t             head,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  fetch_entry_t   mem [DEPTH];
  logic [AW-1:0]  wr_ptr;
  logic [AW-1:0]  rd_ptr;
  logic [CW-1:0]  cnt;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      cnt <= cnt + CW'(push) - CW'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (push && !flush) mem[wr_ptr] <= wdata;
  end

  assign head  = mem[rd_ptr];
  assign count = cnt;

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch stage: credit-limited imem requests, in-order responses.
// Optional perf counters enabled by FETCH_STAGE_PERF_EN.
module fetch_stage
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter int          BUF_DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req_valid,
  output logic [31:0] imem_req_addr,
  input  logic        imem_req_ready,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        if_valid,
  output logic [31:0] if_instr,
  output logic [31:0] if_pc,
  input  logic        if_ready
`ifdef FETCH_STAGE_PERF_EN
  ,
  output logic [31:0] perf_fetch_cnt,
  output logic [31:0] perf_stall_cnt
`endif
);

  localparam int CW = $clog2(BUF_DEPTH) + 1;

  logic            run;
  logic [XLEN-1:0] fetch_pc;
  logic [CW-1:0]   drop_cnt;
  logic [CW-1:0]   drop_nxt;
  logic [CW-1:0]   unret;
  logic [CW-1:0]   occ;
  logic [CW-1:0]   outs;
  logic [CW:0]     inflight;
  logic            req_fire;
  logic            rsp_take;
  logic            rsp_drop;
  logic            deq;

  fetch_entry_t pcq_in;
  fetch_entry_t pcq_head;
  fetch_entry_t obuf_in;
  fetch_entry_t obuf_head;

  // Dropped responses still occupy imem, so they consume credit.
  assign inflight = {1'b0, occ} + {1'b0, outs} + {1'b0, drop_cnt};

  assign imem_req_valid = run && !redirect_valid
                       && (inflight < (CW+1)'(BUF_DEPTH));
  assign imem_req_addr  = fetch_pc;
  assign req_fire       = imem_req_valid && imem_req_ready;

  assign rsp_drop = run && imem_rsp_valid && (drop_cnt != '0);
  assign rsp_take = run && imem_rsp_valid && (drop_cnt == '0)
                 && !redirect_valid && (outs != '0);

  assign if_valid = run && (occ != '0);
  assign if_pc    = obuf_head.pc;
  assign if_instr = obuf_head.instr;
  assign deq      = if_valid && if_ready;

  always_comb begin
    pcq_in       = '0;
    pcq_in.pc    = fetch_pc;
    obuf_in      = pcq_head;
    obuf_in.instr = imem_rsp_data;
  end

  fetch_fifo #(.DEPTH(BUF_DEPTH)) u_pcq (
    .clk   (clk),
    .rst_n (rst_n),
    .flush (redirect_valid),
    .push  (req_fire),
    .wdata (pcq_in),
    .pop   (rsp_take),
    .head  (pcq_head),
    .count (outs)
  );

  fetch_fifo #(.DEPTH(BUF_DEPTH)) u_obuf (
    .clk   (clk),
    .rst_n (rst_n),
    .flush (redirect_valid),
    .push  (rsp_take),
    .wdata (obuf_in),
    .pop   (deq),
    .head  (obuf_head),
    .count (occ)
  );

  // A response arriving with the redirect retires the oldest unreturned one.
  always_comb begin
    unret    = drop_cnt + outs;
    drop_nxt = drop_cnt;
    if (redirect_valid) begin
      if (run && imem_rsp_valid && (unret != '0)) begin
        drop_nxt = unret - 1'b1;
      end else begin
        drop_nxt = unret;
      end
    end else if (rsp_drop) begin
      drop_nxt = drop_cnt - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      run      <= 1'b0;
      fetch_pc <= align_pc(RESET_PC);
      drop_cnt <= '0;
    end else begin
      run      <= 1'b1;
      drop_cnt <= drop_nxt;
      if (redirect_valid) begin
        fetch_pc <= align_pc(redirect_pc);
      end else if (req_fire) begin
        fetch_pc <= fetch_pc + PC_STEP;
      end
    end
  end

`ifdef FETCH_STAGE_PERF_EN
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      perf_fetch_cnt <= '0;
      perf_stall_cnt <= '0;
    end else begin
      if (deq) perf_fetch_cnt <= perf_fetch_cnt + 1'b1;
      if (if_valid && !if_ready) begin
        perf_stall_cnt <= perf_stall_cnt + 1'b1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Scoreboard bench for fetch_stage with an in-order imem model.
module tb_fetch_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        imem_req_valid;
  logic [31:0] imem_req_addr;
  logic        imem_req_ready;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        if_valid;
  logic [31:0] if_instr;
  logic [31:0] if_pc;
  logic        if_ready;
`ifdef FETCH_STAGE_PERF_EN
  logic [31:0] perf_fetch_cnt;
  logic [31:0] perf_stall_cnt;
`endif

  fetch_stage dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .imem_req_valid (imem_req_valid),
    .imem_req_addr  (imem_req_addr),
    .imem_req_ready (imem_req_ready),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .if_valid       (if_valid),
    .if_instr       (if_instr),
    .if_pc          (if_pc),
    .if_ready       (if_ready)
`ifdef FETCH_STAGE_PERF_EN
    ,
    .perf_fetch_cnt (perf_fetch_cnt),
    .perf_stall_cnt (perf_stall_cnt)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int hs_cnt = 0;
  int cyc = 0;
  int lat = 1;

  typedef struct {
    logic [31:0] addr;
    int          due;
  } pend_t;

  pend_t       pq [$];
  logic [31:0] exp_q [$];
  logic [31:0] e;

  function automatic logic [31:0] word(input logic [31:0] a);
    return a ^ 32'hC0DE_0013;
  endfunction

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] want);
    checks++;
    if (act !== want) begin
      errors++;
      $display("FAIL %s got %h want %h", name, act, want);
    end
  endtask

  // imem: in order, one response per cycle, lat cycles after acceptance
  always @(posedge clk) begin
    cyc++;
    if (!rst_n) begin
      pq.delete();
    end else if (imem_req_valid && imem_req_ready) begin
      pq.push_back('{imem_req_addr, cyc + lat - 1});
      hs_cnt++;
    end
    #1;
    if (pq.size() > 0 && pq[0].due <= cyc) begin
      imem_rsp_valid = 1'b1;
      imem_rsp_data  = word(pq[0].addr);
      void'(pq.pop_front());
    end else begin
      imem_rsp_valid = 1'b0;
      imem_rsp_data  = '0;
    end
  end

  always @(negedge clk) begin
    if (rst_n && if_valid && if_ready) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL pop_unexpected got pc=%h", if_pc);
      end else begin
        e = exp_q.pop_front();
        if (if_pc !== e || if_instr !== word(e)) begin
          errors++;
          $display("FAIL pop got pc=%h instr=%h want pc=%h instr=%h",
                   if_pc, if_instr, e, word(e));
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic issue(input int n);
    int base;
    base = hs_cnt;
    imem_req_ready = 1'b1;
    for (int i = 0; i < 100; i++) begin
      step();
      if (hs_cnt - base >= n) break;
    end
    imem_req_ready = 1'b0;
    chk("issue_count", 32'(hs_cnt - base), 32'(n));
  endtask

  task automatic redirect(input logic [31:0] pc);
    redirect_pc    = pc;
    redirect_valid = 1'b1;
    #1;
    chk("redir_req_valid", {31'b0, imem_req_valid}, 32'd0);
    step();
    redirect_valid = 1'b0;
    #1;
  endtask

  task automatic drain();
    for (int i = 0; i < 100; i++) begin
      if (exp_q.size() == 0) break;
      step();
    end
    chk("drain_left", 32'(exp_q.size()), 32'd0);
    repeat (4) step();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    int first;
    int base;
    rst_n          = 1'b0;
    imem_req_ready = 1'b1;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    if_ready       = 1'b1;
    repeat (3) step();
    chk("rst_if_valid", {31'b0, if_valid}, 32'd0);
    chk("rst_req_valid", {31'b0, imem_req_valid}, 32'd0);

    // streaming from reset
    for (int i = 0; i < 8; i++) exp_q.push_back(32'(i * 4));
    base  = hs_cnt;
    rst_n = 1'b1;
    #1;
    chk("post_rst_req_valid", {31'b0, imem_req_valid}, 32'd0);
    chk("post_rst_if_valid", {31'b0, if_valid}, 32'd0);
    first = 0;
    for (int i = 1; i <= 20; i++) begin
      step();
      if (first == 0 && if_valid) first = i;
      if (hs_cnt - base >= 8) imem_req_ready = 1'b0;
    end
    chk("first_if_valid_le3", {31'b0, first >= 1 && first <= 3}, 32'd1);
    chk("stream_reqs", 32'(hs_cnt - base), 32'd8);
    drain();
`ifdef FETCH_STAGE_PERF_EN
    chk("perf_fetch", perf_fetch_cnt, 32'd8);
`endif

    // decode stalled for 20 cycles
    if_ready = 1'b0;
    for (int i = 0; i < 4; i++) exp_q.push_back(32'h20 + 32'(i * 4));
    base = hs_cnt;
    imem_req_ready = 1'b1;
    for (int i = 1; i <= 20; i++) begin
      step();
      if (i >= 5) begin
        chk("stall_valid", {31'b0, if_valid}, 32'd1);
        chk("stall_pc", if_pc, 32'h20);
        chk("stall_instr", if_instr, word(32'h20));
      end
    end
    chk("stall_reqs", 32'(hs_cnt - base), 32'd4);
    imem_req_ready = 1'b0;
    if_ready = 1'b1;
    drain();

    // redirect with two requests in flight
    lat = 3;
    issue(2);
    redirect(32'h100);
    exp_q.push_back(32'h100);
    exp_q.push_back(32'h104);
    issue(2);
    drain();
    lat = 1;

    // misaligned redirect target
    redirect(32'h203);
    chk("align_addr", imem_req_addr, 32'h200);
    chk("resume_valid", {31'b0, imem_req_valid}, 32'd1);
    exp_q.push_back(32'h200);
    exp_q.push_back(32'h204);
    issue(2);
    drain();

    // PC wrap
    redirect(32'hFFFF_FFFC);
    exp_q.push_back(32'hFFFF_FFFC);
    exp_q.push_back(32'h0);
    issue(2);
    drain();
    chk("wrap_next_addr", imem_req_addr, 32'h4);

    // reset with a full buffer
    if_ready = 1'b0;
    issue(4);
    repeat (3) step();
    chk("full_valid", {31'b0, if_valid}, 32'd1);
    chk("full_head", if_pc, 32'h4);
    chk("full_no_req", {31'b0, imem_req_valid}, 32'd0);
    rst_n = 1'b0;
    step();
    chk("mid_rst_if_valid", {31'b0, if_valid}, 32'd0);
    chk("mid_rst_req_valid", {31'b0, imem_req_valid}, 32'd0);
    rst_n = 1'b1;
    #1;
    chk("mid_post_if_valid", {31'b0, if_valid}, 32'd0);
    chk("mid_post_req_valid", {31'b0, imem_req_valid}, 32'd0);
`ifdef FETCH_STAGE_PERF_EN
    chk("perf_fetch_rst", perf_fetch_cnt, 32'd0);
    chk("perf_stall_rst", perf_stall_cnt, 32'd0);
`endif
    step();
    chk("restart_valid", {31'b0, imem_req_valid}, 32'd1);
    chk("restart_addr", imem_req_addr, 32'h0);
    if_ready = 1'b1;
    exp_q.push_back(32'h0);
    exp_q.push_back(32'h4);
    issue(2);
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
